axi_ar_decoder_ordered: RTL and testbench

- Read-address-channel decoder for the AXI node, parametrised in region count, initiator-port count and outstanding depth.
- Per-port remap table selects the target port. Tracks outstanding reads and stalls any request to a different target until earlier reads drain, so reads return in order.
- Owns error sequencing internally: drain outstanding reads, then request an error response.
- Sits between one slave-side AR input and the N_INIT_PORT master-side AR outputs of the node.

---
 rtl/axi_node_dec_pkg.sv | 25 ++
 rtl/axi_ar_decoder_ordered_chk.sv | 28 ++
 rtl/axi_ar_decoder_ordered_region_match.sv | 46 ++++
 rtl/axi_ar_decoder_ordered.sv | 205 ++++++++++++++++++++
 tb/tb_axi_ar_decoder_ordered.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_node_dec_pkg.sv
// ---------------------------------------------------------------------------
// axi_node_dec_pkg
// Shared types and helpers for the AXI node read-address decoder.
//   dec_state_e    : decoder control state (normal routing / error drain /
//                    error request towards the error slave)
//   lowest_onehot  : isolates the lowest set bit of a vector (up to
//                    ONEHOT_W bits), used to arbitrate multiple region hits
// ---------------------------------------------------------------------------
package axi_node_dec_pkg;

  typedef enum logic [1:0] {
    OPERATIVE = 2'd0,
    ERR_DRAIN = 2'd1,
    ERR_REQ   = 2'd2
  } dec_state_e;

  // Widest port vector the one-hot helper supports.
  localparam int unsigned ONEHOT_W = 64;

  // Two's-complement trick: vec & -vec keeps only the lowest set bit.
  function automatic logic [ONEHOT_W-1:0] lowest_onehot(input logic [ONEHOT_W-1:0] vec);
    return vec & (~vec + 64'd1);
  endfunction

endpackage

// File: rtl/axi_ar_decoder_ordered_chk.sv
// ---------------------------------------------------------------------------
// axi_ar_decoder_ordered_chk
// Simulation checks for the ordered read-address decoder.
//   clk, rst_n     : decoder clock and asynchronous active-low reset
//   rdone_i        : read completion pulse seen by the decoder
//   outstanding_i  : decoder in-flight read count
//   arvalid_i      : decoder per-target valid vector
// ---------------------------------------------------------------------------
module axi_ar_decoder_ordered_chk #(
  parameter int unsigned N_INIT_PORT = 8,
  parameter int unsigned CNT_W       = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   rdone_i,
  input logic [CNT_W-1:0]       outstanding_i,
  input logic [N_INIT_PORT-1:0] arvalid_i
);

  // A completion with nothing in flight is a protocol error upstream.
  rdone_with_zero_count: assert property (
    @(posedge clk) disable iff (!rst_n) rdone_i |-> (outstanding_i != '0));

  // Only one target may ever see a valid request.
  arvalid_onehot: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(arvalid_i));

endmodule

// File: rtl/axi_ar_decoder_ordered_region_match.sv
// ---------------------------------------------------------------------------
// axi_dec_region_match
// Combinational address match for the read-address decoder.
//   araddr_i           : request address
//   START_ADDR_i       : per region / logical port start address (inclusive)
//   END_ADDR_i         : per region / logical port end address (inclusive)
//   enable_region_i    : per region / logical port enable
//   connectivity_map_i : physical ports reachable from this slave port
//   remap_i            : logical port -> physical port translation
//   match_o            : physical-port hit vector (may hold several bits)
// ---------------------------------------------------------------------------
module axi_dec_region_match #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned N_INIT_PORT = 8,
  parameter int unsigned LOG_N_INIT  = 3,
  parameter int unsigned N_REGION    = 4
) (
  input  logic [ADDR_WIDTH-1:0]                                  araddr_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0]   START_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0]   END_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0]                   enable_region_i,
  input  logic [N_INIT_PORT-1:0]                                 connectivity_map_i,
  input  logic [N_INIT_PORT-1:0][LOG_N_INIT-1:0]                 remap_i,
  output logic [N_INIT_PORT-1:0]                                 match_o
);

  logic [N_INIT_PORT-1:0] phys_hit_s;

  // Accumulate hits of every enabled region onto the remapped physical port.
  // A remap value beyond the port count shifts out and contributes nothing.
  always_comb begin
    phys_hit_s = '0;
    for (int j = 0; j < N_REGION; j++) begin
      for (int i = 0; i < N_INIT_PORT; i++) begin
        phys_hit_s = phys_hit_s |
          ((enable_region_i[j][i] &&
            (araddr_i >= START_ADDR_i[j][i]) &&
            (araddr_i <= END_ADDR_i[j][i]))
           ? (N_INIT_PORT'(1) << remap_i[i]) : '0);
      end
    end
  end

  assign match_o = phys_hit_s & connectivity_map_i;

endmodule

// File: rtl/axi_ar_decoder_ordered.sv
// ---------------------------------------------------------------------------
// axi_ar_decoder_ordered
// Read-address decoder that keeps read responses in order: requests to a
// new target stall until all reads to the current target have completed.
// Unmapped requests are accepted once, then outstanding reads drain and an
// error response is requested from the error slave.
//
// Optional feature macro: AXI_AR_DECODER_DEFAULT_PORT_EN
//   When defined, unmapped requests go to parameter DEFAULT_PORT under the
//   normal ordering rules and the error flow is removed.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   arvalid_i, araddr_i  : request from the master side
//   arready_o            : request accepted (combinational)
//   arvalid_o            : one-hot valid towards the targets (combinational)
//   arready_i            : per-target ready
//   START_ADDR_i, END_ADDR_i, enable_region_i : address map
//   connectivity_map_i   : reachable physical ports
//   remap_i              : logical -> physical port remap
//   rdone_i              : one read fully returned to the master
//   error_req_o          : registered error-response request
//   error_gnt_i          : error slave accepted the request
//   sample_ardata_info_o : capture ID/len of the failing request
//   outstanding_o        : in-flight read count
//   busy_target_o        : physical port of the in-flight reads
// ---------------------------------------------------------------------------
module axi_ar_decoder_ordered
  import axi_node_dec_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned N_INIT_PORT     = 8,
  parameter int unsigned LOG_N_INIT      = 3,
  parameter int unsigned N_REGION        = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CNT_W           = 4
`ifdef AXI_AR_DECODER_DEFAULT_PORT_EN
  , parameter int unsigned DEFAULT_PORT  = 0
`endif
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 arvalid_i,
  input  logic [ADDR_WIDTH-1:0]                                araddr_i,
  output logic                                                 arready_o,
  output logic [N_INIT_PORT-1:0]                               arvalid_o,
  input  logic [N_INIT_PORT-1:0]                               arready_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] START_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0] END_ADDR_i,
  input  logic [N_REGION-1:0][N_INIT_PORT-1:0]                 enable_region_i,
  input  logic [N_INIT_PORT-1:0]                               connectivity_map_i,
  input  logic [N_INIT_PORT-1:0][LOG_N_INIT-1:0]               remap_i,
  input  logic                                                 rdone_i,
  output logic                                                 error_req_o,
  input  logic                                                 error_gnt_i,
  output logic                                                 sample_ardata_info_o,
  output logic [CNT_W-1:0]                                     outstanding_o,
  output logic [LOG_N_INIT-1:0]                                busy_target_o
);

  dec_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LOG_N_INIT-1:0]  tgt_q, tgt_d;
  logic                   error_req_q;

  logic [N_INIT_PORT-1:0] match_s;
  logic [N_INIT_PORT-1:0] sel_s;
  logic [N_INIT_PORT-1:0] route_sel_s;
  logic                   route_hit_s;
  logic [LOG_N_INIT-1:0]  route_idx_s;
  logic                   allowed_s;
  logic                   accept_s;
  logic                   rd_ok_s;
  logic                   drain_done_s;
  logic                   sample_s;
  logic                   arready_s;
  logic [N_INIT_PORT-1:0] arvalid_s;

  axi_dec_region_match #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .N_INIT_PORT (N_INIT_PORT),
    .LOG_N_INIT  (LOG_N_INIT),
    .N_REGION    (N_REGION)
  ) u_match (
    .araddr_i           (araddr_i),
    .START_ADDR_i       (START_ADDR_i),
    .END_ADDR_i         (END_ADDR_i),
    .enable_region_i    (enable_region_i),
    .connectivity_map_i (connectivity_map_i),
    .remap_i            (remap_i),
    .match_o            (match_s)
  );

  // Lowest physical index wins when several regions hit.
  assign sel_s = N_INIT_PORT'(lowest_onehot(ONEHOT_W'(match_s)));

`ifdef AXI_AR_DECODER_DEFAULT_PORT_EN
  assign route_hit_s = 1'b1;
  assign route_sel_s = (|match_s) ? sel_s : (N_INIT_PORT'(1) << DEFAULT_PORT);
`else
  assign route_hit_s = |match_s;
  assign route_sel_s = sel_s;
`endif

  // Encode the one-hot route into a port index.
  always_comb begin
    route_idx_s = '0;
    for (int k = 0; k < N_INIT_PORT; k++) begin
      route_idx_s = route_idx_s | (route_sel_s[k] ? LOG_N_INIT'(k) : '0);
    end
  end

  // Ordering rule: idle, or same target with room for another read.
  assign allowed_s = (cnt_q == '0) ||
                     ((cnt_q < CNT_W'(MAX_OUTSTANDING)) && (route_idx_s == tgt_q));

  assign accept_s = |(arvalid_s & arready_i);
  assign rd_ok_s  = rdone_i && (cnt_q != '0);

  // Drain is complete when the count is zero now or reaches zero this cycle.
  assign drain_done_s = (cnt_q == '0) || ((cnt_q == CNT_W'(1)) && rdone_i);

  // Next-state and zero-latency handshake decode.
  always_comb begin
    state_d   = state_q;
    arvalid_s = '0;
    arready_s = 1'b0;
    sample_s  = 1'b0;
    case (state_q)
      OPERATIVE: begin
        if (arvalid_i) begin
          if (route_hit_s) begin
            if (allowed_s) begin
              arvalid_s = route_sel_s;
              arready_s = arready_i[route_idx_s];
            end else begin
              arvalid_s = '0;
            end
          end else begin
            arready_s = 1'b1;
            sample_s  = 1'b1;
            state_d   = ERR_DRAIN;
          end
        end else begin
          state_d = OPERATIVE;
        end
      end
      ERR_DRAIN: state_d = drain_done_s ? ERR_REQ : ERR_DRAIN;
      ERR_REQ:   state_d = error_gnt_i ? OPERATIVE : ERR_REQ;
      default:   state_d = OPERATIVE;
    endcase
  end

  // Outstanding counter: saturates at the limit and never goes below zero.
  always_comb begin
    cnt_d = cnt_q;
    case ({accept_s, rd_ok_s})
      2'b10:   cnt_d = (cnt_q < CNT_W'(MAX_OUTSTANDING)) ? (cnt_q + CNT_W'(1)) : cnt_q;
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign tgt_d = accept_s ? route_idx_s : tgt_q;

  // State, counter, target and error-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OPERATIVE;
      cnt_q       <= '0;
      tgt_q       <= '0;
      error_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      error_req_q <= (state_d == ERR_REQ);
    end
  end

  assign arvalid_o     = arvalid_s;
  assign arready_o     = arready_s;
  assign outstanding_o = cnt_q;
  assign busy_target_o = tgt_q;

`ifdef AXI_AR_DECODER_DEFAULT_PORT_EN
  assign error_req_o          = 1'b0;
  assign sample_ardata_info_o = 1'b0;
`else
  assign error_req_o          = error_req_q;
  assign sample_ardata_info_o = sample_s;
`endif

  axi_ar_decoder_ordered_chk #(
    .N_INIT_PORT (N_INIT_PORT),
    .CNT_W       (CNT_W)
  ) u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .rdone_i       (rdone_i),
    .outstanding_i (cnt_q),
    .arvalid_i     (arvalid_s)
  );

endmodule

// File: tb/tb_axi_ar_decoder_ordered.sv
module tb_axi_ar_decoder_ordered;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   arvalid;
  logic [31:0]            araddr;
  logic                   arready_o;
  logic [7:0]             arvalid_o;
  logic [7:0]             arready;
  logic [3:0][7:0][31:0]  start_a;
  logic [3:0][7:0][31:0]  end_a;
  logic [3:0][7:0]        en;
  logic [7:0]             conn;
  logic [7:0][2:0]        remap;
  logic                   rdone;
  logic                   error_req_o;
  logic                   gnt;
  logic                   sample_o;
  logic [3:0]             outstanding_o;
  logic [2:0]             busy_o;

  int n_run  = 0;
  int n_fail = 0;

  axi_ar_decoder_ordered dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .arvalid_i            (arvalid),
    .araddr_i             (araddr),
    .arready_o            (arready_o),
    .arvalid_o            (arvalid_o),
    .arready_i            (arready),
    .START_ADDR_i         (start_a),
    .END_ADDR_i           (end_a),
    .enable_region_i      (en),
    .connectivity_map_i   (conn),
    .remap_i              (remap),
    .rdone_i              (rdone),
    .error_req_o          (error_req_o),
    .error_gnt_i          (gnt),
    .sample_ardata_info_o (sample_o),
    .outstanding_o        (outstanding_o),
    .busy_target_o        (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic [7:0]  ready;
    logic [2:0]  remap3;
    logic [7:0]  conn;
    logic [7:0]  exp_v;
    logic        exp_r;
    logic        exp_s;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Address map: region 0 of ports 0,1,2,3,5 plus an overlapping region 1 on port 4.
    start_a = '0; end_a = '0; en = '0;
    start_a[0][0] = 32'h0000_0000; end_a[0][0] = 32'h0000_0FFF; en[0][0] = 1'b1;
    start_a[0][1] = 32'h0000_2000; end_a[0][1] = 32'h0000_2FFF; en[0][1] = 1'b1;
    start_a[0][2] = 32'h0000_1000; end_a[0][2] = 32'h0000_1FFF; en[0][2] = 1'b1;
    start_a[0][3] = 32'h0000_3000; end_a[0][3] = 32'h0000_3FFF; en[0][3] = 1'b1;
    start_a[0][5] = 32'h0000_5000; end_a[0][5] = 32'h0000_5FFF; en[0][5] = 1'b1;
    start_a[1][4] = 32'h0000_1800; end_a[1][4] = 32'h0000_18FF; en[1][4] = 1'b1;
    for (int i = 0; i < 8; i++) remap[i] = 3'(i);
    conn = 8'hFF; arready = 8'hFF; arvalid = 1'b0; araddr = 32'h0;
    rdone = 1'b0; gnt = 1'b0; rst_n = 1'b0;

    //          valid addr           ready  rmp3  conn   exp_v  r     s
    vecs[0]  = '{1'b0, 32'h0000_1004, 8'hFF, 3'd3, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_1004, 8'hFF, 3'd3, 8'hFF, 8'h04, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_1004, 8'h00, 3'd3, 8'hFF, 8'h04, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_1000, 8'h04, 3'd3, 8'hFF, 8'h04, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_1FFF, 8'hFB, 3'd3, 8'hFF, 8'h04, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0FFF, 8'h01, 3'd3, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_2000, 8'hFD, 3'd3, 8'hFF, 8'h02, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_3010, 8'h40, 3'd6, 8'hFF, 8'h40, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_3010, 8'h08, 3'd3, 8'hFF, 8'h08, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_1810, 8'hFF, 3'd3, 8'hFF, 8'h04, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_1810, 8'hFF, 3'd3, 8'hFB, 8'h10, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 32'hFFFF_0000, 8'h00, 3'd3, 8'hFF, 8'h00, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 32'h0000_3010, 8'hFF, 3'd6, 8'hBF, 8'h00, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 32'h0000_6000, 8'hFF, 3'd3, 8'hFF, 8'h00, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 32'h0000_3010, 8'hFF, 3'd3, 8'hF7, 8'h00, 1'b1, 1'b1};

    // Reset state.
    #2;
    chk("rst outstanding", outstanding_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst error_req", error_req_o, 0);
    chk("rst arready", arready_o, 0);
    chk("rst sample", sample_o, 0);
    @(negedge clk); rst_n = 1'b1;

    // Zero-latency decode table; arvalid is dropped before each clock edge.
    for (int v = 0; v < 15; v++) begin
      @(negedge clk);
      arvalid = vecs[v].valid; araddr = vecs[v].addr; arready = vecs[v].ready;
      remap[3] = vecs[v].remap3; conn = vecs[v].conn;
      #1;
      chk($sformatf("vec%0d arvalid_o", v), arvalid_o, vecs[v].exp_v);
      chk($sformatf("vec%0d arready_o", v), arready_o, vecs[v].exp_r);
      chk($sformatf("vec%0d sample", v), sample_o, vecs[v].exp_s);
      arvalid = 1'b0;
    end
    remap[3] = 3'd3; conn = 8'hFF; arready = 8'hFF;
    chk("table outstanding", outstanding_o, 0);

    // Ordered passthrough: four reads to port 2.
    @(negedge clk);
    araddr = 32'h0000_1004; arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("pass%0d arvalid_o", i), arvalid_o, 8'h04);
      clk1;
    end
    arvalid = 1'b0;
    #1 chk("pass outstanding", outstanding_o, 4);
    chk("pass busy", busy_o, 2);

    // Target switch stall.
    rdone = 1'b1; clk1; clk1; rdone = 1'b0;
    #1 chk("sw outstanding2", outstanding_o, 2);
    araddr = 32'h0000_5000; arvalid = 1'b1;
    #1 chk("sw stall arvalid_o", arvalid_o, 0);
    chk("sw stall arready", arready_o, 0);
    rdone = 1'b1; clk1;
    #1 chk("sw stall cnt1 arvalid_o", arvalid_o, 0);
    clk1; rdone = 1'b0;
    #1 chk("sw drained", outstanding_o, 0);
    chk("sw release arvalid_o", arvalid_o, 8'h20);
    chk("sw release arready", arready_o, 1);
    clk1; arvalid = 1'b0;
    #1 chk("sw outstanding1", outstanding_o, 1);
    chk("sw busy", busy_o, 5);

    // Full: MAX_OUTSTANDING reads to port 1, then one more stalls.
    rdone = 1'b1; clk1; rdone = 1'b0;
    araddr = 32'h0000_2000; arvalid = 1'b1;
    repeat (8) clk1;
    #1 chk("full outstanding", outstanding_o, 8);
    chk("full busy", busy_o, 1);
    chk("full stall arvalid_o", arvalid_o, 0);
    chk("full stall arready", arready_o, 0);
    rdone = 1'b1;
    #1 chk("full rdone same cycle stall", arvalid_o, 0);
    clk1; rdone = 1'b0;
    #1 chk("full release cnt", outstanding_o, 7);
    chk("full release arvalid_o", arvalid_o, 8'h02);
    clk1;
    #1 chk("full refill", outstanding_o, 8);
    arvalid = 1'b0; rdone = 1'b1; clk1;
    arvalid = 1'b1;
    #1 chk("accrd arvalid_o", arvalid_o, 8'h02);
    clk1; arvalid = 1'b0; rdone = 1'b0;
    #1 chk("accrd outstanding kept", outstanding_o, 7);
    rdone = 1'b1; repeat (7) clk1; rdone = 1'b0;
    #1 chk("full drained", outstanding_o, 0);

    // Error with drain.
    araddr = 32'h0000_0100; arvalid = 1'b1;
    repeat (3) clk1;
    arvalid = 1'b0;
    #1 chk("err outstanding3", outstanding_o, 3);
    chk("err busy0", busy_o, 0);
    araddr = 32'hFFFF_0000; arvalid = 1'b1;
    #1 chk("err arready", arready_o, 1);
    chk("err sample", sample_o, 1);
    chk("err arvalid_o", arvalid_o, 0);
    clk1; arvalid = 1'b0;
    #1 chk("err sample one cycle", sample_o, 0);
    araddr = 32'h0000_0100; arvalid = 1'b1;
    #1 chk("drain blocks arvalid_o", arvalid_o, 0);
    chk("drain blocks arready", arready_o, 0);
    arvalid = 1'b0;
    gnt = 1'b1; rdone = 1'b1; clk1; gnt = 1'b0;
    clk1;
    #1 chk("drain error_req low", error_req_o, 0);
    chk("drain outstanding1", outstanding_o, 1);
    clk1; rdone = 1'b0;
    #1 chk("drain error_req high", error_req_o, 1);
    chk("drain outstanding0", outstanding_o, 0);
    clk1;
    #1 chk("error_req held", error_req_o, 1);
    gnt = 1'b1; clk1; gnt = 1'b0;
    #1 chk("gnt clears error_req", error_req_o, 0);
    arready = 8'h00; araddr = 32'h0000_1004; arvalid = 1'b1;
    #1 chk("back operative", arvalid_o, 8'h04);
    arvalid = 1'b0; arready = 8'hFF;

    // Remap target disconnected -> error path.
    remap[3] = 3'd6; conn = 8'hBF; araddr = 32'h0000_3010; arvalid = 1'b1;
    #1 chk("conn err sample", sample_o, 1);
    chk("conn err arvalid_o", arvalid_o, 0);
    clk1; arvalid = 1'b0;
    clk1;
    #1 chk("conn err error_req", error_req_o, 1);
    gnt = 1'b1; clk1; gnt = 1'b0; remap[3] = 3'd3; conn = 8'hFF;
    #1 chk("conn err cleared", error_req_o, 0);

    // Async reset with count 4 in ERR_DRAIN.
    araddr = 32'h0000_1004; arvalid = 1'b1;
    repeat (4) clk1;
    araddr = 32'hFFFF_0000;
    clk1; arvalid = 1'b0;
    #1 chk("prerst outstanding", outstanding_o, 4);
    #2 rst_n = 1'b0;
    #1 chk("arst outstanding", outstanding_o, 0);
    chk("arst busy", busy_o, 0);
    chk("arst error_req", error_req_o, 0);
    chk("arst arready", arready_o, 0);
    chk("arst arvalid_o", arvalid_o, 0);
    clk1;
    @(negedge clk); rst_n = 1'b1;
    arready = 8'h00; araddr = 32'h0000_5000; arvalid = 1'b1;
    #1 chk("post rst operative", arvalid_o, 8'h20);
    arvalid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
